// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the Y86-64 data-memory responder.
// Imported by the responder top, its byte array and its bus interface.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

    // Y86-64 status codes; the core turns resp_err_o into SADR
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    localparam int DMEM_DEPTH_BYTES  = 1024;
    localparam int DMEM_ACCESS_BYTES = 8;

    function automatic logic [2:0] dmem_status(input logic err);
        return err ? SADR : SAOK;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory-access stage and the data-memory responder.
// The master is the core side; the slave is dmem_responder.
interface dmem_responder_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;
    logic        busy_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o
    );

endinterface

// File: rtl/dmem_responder_byte_array.sv
// Byte-addressable storage with an 8-byte little-endian write port and a combinational 8-byte read.
// Holds no reset so contents survive a responder reset.
module dmem_byte_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = DMEM_DEPTH_BYTES,
    parameter int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [7:0] mem [DEPTH_BYTES];

    // The caller range-checks addr, so addr+7 always lands inside the array when used
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DMEM_ACCESS_BYTES; i++) begin
                mem[addr + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < DMEM_ACCESS_BYTES; i++) begin
            rdata[8*i +: 8] = mem[addr + AW'(i)];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one 8-byte load/store, waits LATENCY cycles, then holds
// the response until the requester consumes it. busy_o lets the core stall M/W meanwhile.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = DMEM_DEPTH_BYTES,
    parameter int LATENCY     = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    dmem_responder_if.slave  bus
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] LAST_LEGAL = 64'(DEPTH_BYTES - DMEM_ACCESS_BYTES);

    dmem_state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic        capture, access;
    logic        write_q;
    logic [63:0] addr_q, wdata_q;
    logic [63:0] rdata_q;
    logic        err_q;
    logic        addr_err;
    logic        array_we;
    logic [63:0] array_rdata;

    // Full-width unsigned compare so huge addresses never wrap into range
    assign addr_err = (addr_q > LAST_LEGAL);
    assign array_we = access && write_q && !addr_err;

    dmem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_array (
        .clk   (clk_i),
        .we    (array_we),
        .addr  (addr_q[AW-1:0]),
        .wdata (wdata_q),
        .rdata (array_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= DMEM_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        access     = 1'b0;
        unique case (state)
            DMEM_IDLE: begin
                if (bus.req_valid_i) begin
                    capture    = 1'b1;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    state_next = DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    access     = 1'b1;
                    state_next = DMEM_RESP;
                end
            end
            DMEM_RESP: begin
                if (bus.resp_ready_i) begin
                    state_next = DMEM_IDLE;
                end
            end
            default: state_next = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (capture) begin
                write_q <= bus.req_write_i;
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
            end
            if (access) begin
                err_q   <= addr_err;
                rdata_q <= (write_q || addr_err) ? 64'd0 : array_rdata;
            end
        end
    end

    assign bus.req_ready_o  = (state == DMEM_IDLE);
    assign bus.resp_valid_o = (state == DMEM_RESP);
    assign bus.busy_o       = (state != DMEM_IDLE);
    assign bus.resp_rdata_o = rdata_q;
    assign bus.resp_err_o   = err_q;

endmodule
